// File: rtl/laser_aom_controller_pkg.sv
// -----------------------------------------------------------------------------
// laser_aom_controller_pkg
// Shared widths, the class-table constants, the output source-select encoding
// and the clamp helper used by the AOM drive-level controller.
// -----------------------------------------------------------------------------
package laser_aom_controller_pkg;

    localparam int DAC_W       = 12;   // AD5445 code width
    localparam int CNT_W       = 32;   // PWM period / high-time counter width
    localparam int NUM_CLASSES = 8;    // class0 (gate closed) + classes 1..7
    localparam int IDX_W       = 3;

    localparam logic [IDX_W-1:0] IDX_FIRST = 3'd1;
    localparam logic [IDX_W-1:0] IDX_LAST  = 3'd7;

    typedef enum logic [1:0] {
        SRC_ERR    = 2'd0,
        SRC_ACC    = 2'd1,
        SRC_ANALOG = 2'd2,
        SRC_IDLE   = 2'd3
    } src_sel_e;

    // The upper limit is applied last so it wins when the limits cross.
    function automatic logic [DAC_W-1:0] clamp_level(
        input logic [DAC_W-1:0] level,
        input logic [DAC_W-1:0] lo,
        input logic [DAC_W-1:0] hi
    );
        logic [DAC_W-1:0] t;
        t = (level < lo) ? lo : level;
        return (t > hi) ? hi : t;
    endfunction

endpackage

// File: rtl/laser_aom_controller_pwm_gen.sv
// -----------------------------------------------------------------------------
// laser_pwm_gen
// Analog-mode level generator. Mode 0: free-running period counter, high while
// count < high-time. Mode 1: one high-time pulse per trigger rising edge,
// triggers during a pulse are ignored.
// o_high is the decision for the current cycle; the parent registers it.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             analog mode enabled (counter/pulse held clear when 0)
//   i_mode_sel       0 continuous PWM, 1 single pulse per trigger
//   i_trigger        pulse trigger (rising edge)
//   i_pwm, i_cycle   high-time and period in clk cycles
//   o_high           1 = select high level this cycle
// -----------------------------------------------------------------------------
module laser_pwm_gen
    import laser_aom_controller_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_mode_sel,
    input  logic             i_trigger,
    input  logic [CNT_W-1:0] i_pwm,
    input  logic [CNT_W-1:0] i_cycle,
    output logic             o_high
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_pulse_active;
    logic             w_pulse_next;
    logic             r_trig_d;
    logic             r_mode_d;
    logic             w_trig_rise;
    logic             w_high;

    assign w_trig_rise = i_trigger & ~r_trig_d;
    // Never overflows: r_cnt stays below i_cycle (mode 0) or i_pwm (mode 1).
    assign w_cnt_inc   = r_cnt + 32'd1;

    always_comb begin
        w_cnt_next   = '0;
        w_pulse_next = 1'b0;
        w_high       = 1'b0;
        if (!i_en || (i_mode_sel != r_mode_d)) begin
            // disabled or mode just changed: everything restarts from zero
            w_cnt_next = '0;
        end else if (!i_mode_sel) begin
            if (i_cycle != '0) begin
                w_high     = (r_cnt < i_pwm);
                w_cnt_next = (w_cnt_inc >= i_cycle) ? '0 : w_cnt_inc;
            end
        end else begin
            if (r_pulse_active) begin
                w_high = 1'b1;
                if (w_cnt_inc >= i_pwm) begin
                    w_pulse_next = 1'b0;
                    w_cnt_next   = '0;
                end else begin
                    w_pulse_next = 1'b1;
                    w_cnt_next   = w_cnt_inc;
                end
            end else if (w_trig_rise && (i_pwm != '0)) begin
                // the trigger cycle itself is the first high cycle
                w_high = 1'b1;
                if (i_pwm > 32'd1) begin
                    w_pulse_next = 1'b1;
                    w_cnt_next   = 32'd1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt          <= '0;
            r_pulse_active <= 1'b0;
            r_trig_d       <= 1'b0;
            r_mode_d       <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_pulse_active <= w_pulse_next;
            r_trig_d       <= i_trigger;
            r_mode_d       <= i_mode_sel;
        end
    end

    assign o_high = w_high;

endmodule

// File: rtl/laser_aom_controller.sv
// -----------------------------------------------------------------------------
// laser_aom_controller
// Produces the 12-bit AOM drive code for the AD5445 writer and re-registers the
// laser control/switch lines. Source priority: overload error (0) > acceleration
// job (init level / class levels) > analog PWM or pulse > idle (0). Job and
// analog levels are clamped to [lowlimit, uplimit]. All outputs are registered,
// one clock from input to output; laser_aom_en_o strobes when the code changes
// and once after reset release.
// Ports: clk_i, rst_i (async active-low); laser_* host analog settings;
//   acc_* job control, flag and class levels; aom_*_trig_err_i overload errors;
//   LASER_CONTROL, LASER_OUT_SWITCH, laser_aom_en_o, laser_aom_voltage_o.
// -----------------------------------------------------------------------------
module laser_aom_controller
    import laser_aom_controller_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             laser_control_i,
    input  logic             laser_out_switch_i,
    input  logic [DAC_W-1:0] laser_analog_max_i,
    input  logic [DAC_W-1:0] laser_analog_min_i,
    input  logic [CNT_W-1:0] laser_analog_pwm_i,
    input  logic [CNT_W-1:0] laser_analog_cycle_i,
    input  logic [DAC_W-1:0] laser_analog_uplimit_i,
    input  logic [DAC_W-1:0] laser_analog_lowlimit_i,
    input  logic             laser_analog_mode_sel_i,
    input  logic             laser_analog_trigger_i,
    input  logic             acc_job_control_i,
    input  logic             acc_job_init_switch_i,
    input  logic             acc_job_init_vol_trig_i,
    input  logic [DAC_W-1:0] acc_job_init_vol_i,
    input  logic             acc_aom_flag_i,
    input  logic [DAC_W-1:0] acc_aom_class0_i,
    input  logic [DAC_W-1:0] acc_aom_class1_i,
    input  logic [DAC_W-1:0] acc_aom_class2_i,
    input  logic [DAC_W-1:0] acc_aom_class3_i,
    input  logic [DAC_W-1:0] acc_aom_class4_i,
    input  logic [DAC_W-1:0] acc_aom_class5_i,
    input  logic [DAC_W-1:0] acc_aom_class6_i,
    input  logic [DAC_W-1:0] acc_aom_class7_i,
    input  logic             aom_continuous_trig_err_i,
    input  logic             aom_integral_trig_err_i,
    output logic             LASER_CONTROL,
    output logic             LASER_OUT_SWITCH,
    output logic             laser_aom_en_o,
    output logic [DAC_W-1:0] laser_aom_voltage_o
);

    logic [DAC_W-1:0] w_class [NUM_CLASSES];
    assign w_class[0] = acc_aom_class0_i;
    assign w_class[1] = acc_aom_class1_i;
    assign w_class[2] = acc_aom_class2_i;
    assign w_class[3] = acc_aom_class3_i;
    assign w_class[4] = acc_aom_class4_i;
    assign w_class[5] = acc_aom_class5_i;
    assign w_class[6] = acc_aom_class6_i;
    assign w_class[7] = acc_aom_class7_i;

    logic             r_job_d, r_flag_d, r_init_trig_d;
    logic             r_init_state, r_flag_seen, r_first;
    logic [IDX_W-1:0] r_idx;
    logic             w_init_state_next, w_flag_seen_next;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_job_rise, w_flag_rise, w_init_trig_rise;
    logic [DAC_W-1:0] w_acc_level;
    logic             w_pwm_high;
    src_sel_e         w_src;
    logic [DAC_W-1:0] w_voltage_next;
    logic             w_en_next;
    logic [DAC_W-1:0] r_voltage;
    logic             r_en, r_laser_control, r_out_switch;

    assign w_job_rise       = acc_job_control_i & ~r_job_d;
    assign w_flag_rise      = acc_aom_flag_i & ~r_flag_d;
    assign w_init_trig_rise = acc_job_init_vol_trig_i & ~r_init_trig_d;

    // Job state. The first flag rise after (re)entering init only leaves the
    // init level and shows class1; later rises advance 1..7 and wrap to 1.
    always_comb begin
        w_init_state_next = r_init_state;
        w_flag_seen_next  = r_flag_seen;
        w_idx_next        = r_idx;
        if (!acc_job_control_i) begin
            w_init_state_next = 1'b0;
            w_flag_seen_next  = 1'b0;
            w_idx_next        = IDX_FIRST;
        end else if (w_job_rise || w_init_trig_rise) begin
            w_init_state_next = acc_job_init_switch_i;
            w_flag_seen_next  = 1'b0;
            w_idx_next        = IDX_FIRST;
        end else if (w_flag_rise) begin
            w_init_state_next = 1'b0;
            w_flag_seen_next  = 1'b1;
            if (r_flag_seen) begin
                w_idx_next = (r_idx == IDX_LAST) ? IDX_FIRST : r_idx + 3'd1;
            end
        end
    end

    // Uses next-state values so the new level appears one clock after the edge.
    assign w_acc_level = w_init_state_next ? acc_job_init_vol_i :
                         (acc_aom_flag_i ? w_class[w_idx_next] : w_class[0]);

    laser_pwm_gen u_pwm_gen (
        .i_clk      (clk_i),
        .i_rst_n    (rst_i),
        .i_en       (laser_out_switch_i),
        .i_mode_sel (laser_analog_mode_sel_i),
        .i_trigger  (laser_analog_trigger_i),
        .i_pwm      (laser_analog_pwm_i),
        .i_cycle    (laser_analog_cycle_i),
        .o_high     (w_pwm_high)
    );

    always_comb begin
        w_src = SRC_IDLE;
        if (aom_continuous_trig_err_i || aom_integral_trig_err_i) begin
            w_src = SRC_ERR;
        end else if (acc_job_control_i) begin
            w_src = SRC_ACC;
        end else if (laser_out_switch_i) begin
            w_src = SRC_ANALOG;
        end
    end

    always_comb begin
        w_voltage_next = '0;
        case (w_src)
            SRC_ACC:    w_voltage_next = clamp_level(w_acc_level,
                                             laser_analog_lowlimit_i, laser_analog_uplimit_i);
            SRC_ANALOG: w_voltage_next = clamp_level(w_pwm_high ? laser_analog_max_i : laser_analog_min_i,
                                             laser_analog_lowlimit_i, laser_analog_uplimit_i);
            default:    w_voltage_next = '0;
        endcase
    end

    // r_first forces one strobe after reset so the DAC gets written once.
    assign w_en_next = r_first | (w_voltage_next != r_voltage);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_job_d         <= 1'b0;
            r_flag_d        <= 1'b0;
            r_init_trig_d   <= 1'b0;
            r_init_state    <= 1'b0;
            r_flag_seen     <= 1'b0;
            r_idx           <= IDX_FIRST;
            r_first         <= 1'b1;
            r_voltage       <= '0;
            r_en            <= 1'b0;
            r_laser_control <= 1'b0;
            r_out_switch    <= 1'b0;
        end else begin
            r_job_d         <= acc_job_control_i;
            r_flag_d        <= acc_aom_flag_i;
            r_init_trig_d   <= acc_job_init_vol_trig_i;
            r_init_state    <= w_init_state_next;
            r_flag_seen     <= w_flag_seen_next;
            r_idx           <= w_idx_next;
            r_first         <= 1'b0;
            r_voltage       <= w_voltage_next;
            r_en            <= w_en_next;
            r_laser_control <= laser_control_i;
            r_out_switch    <= laser_out_switch_i;
        end
    end

    assign LASER_CONTROL       = r_laser_control;
    assign LASER_OUT_SWITCH    = r_out_switch;
    assign laser_aom_en_o      = r_en;
    assign laser_aom_voltage_o = r_voltage;

endmodule

// File: tb/tb_laser_aom_controller.sv
module tb_laser_aom_controller;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        laser_control_i, laser_out_switch_i;
    logic [11:0] amax, amin, uplim, lowlim;
    logic [31:0] pwm, cyc;
    logic        mode_sel, trig;
    logic        job, init_sw, init_trig, flag;
    logic [11:0] init_vol;
    logic [11:0] cls [8];
    logic        err_c, err_i;
    logic        LASER_CONTROL, LASER_OUT_SWITCH, en;
    logic [11:0] volt;

    int n_checks = 0;
    int n_errors = 0;
    int strobes;

    always #5 clk = ~clk;

    laser_aom_controller dut (
        .clk_i(clk), .rst_i(rst_i),
        .laser_control_i(laser_control_i), .laser_out_switch_i(laser_out_switch_i),
        .laser_analog_max_i(amax), .laser_analog_min_i(amin),
        .laser_analog_pwm_i(pwm), .laser_analog_cycle_i(cyc),
        .laser_analog_uplimit_i(uplim), .laser_analog_lowlimit_i(lowlim),
        .laser_analog_mode_sel_i(mode_sel), .laser_analog_trigger_i(trig),
        .acc_job_control_i(job), .acc_job_init_switch_i(init_sw),
        .acc_job_init_vol_trig_i(init_trig), .acc_job_init_vol_i(init_vol),
        .acc_aom_flag_i(flag),
        .acc_aom_class0_i(cls[0]), .acc_aom_class1_i(cls[1]),
        .acc_aom_class2_i(cls[2]), .acc_aom_class3_i(cls[3]),
        .acc_aom_class4_i(cls[4]), .acc_aom_class5_i(cls[5]),
        .acc_aom_class6_i(cls[6]), .acc_aom_class7_i(cls[7]),
        .aom_continuous_trig_err_i(err_c), .aom_integral_trig_err_i(err_i),
        .LASER_CONTROL(LASER_CONTROL), .LASER_OUT_SWITCH(LASER_OUT_SWITCH),
        .laser_aom_en_o(en), .laser_aom_voltage_o(volt)
    );

    typedef struct {
        logic        sw;
        logic [11:0] vmax, vmin;
        logic [31:0] vpwm, vcyc;
        logic [11:0] up, low;
        logic        ec, ei;
        logic [11:0] exp_v;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_acc(input string name, input logic [11:0] exp);
        tick();
        check(name, {20'd0, volt}, {20'd0, exp});
        $display("acc %s: voltage %0d", name, volt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        // idle defaults
        rst_i = 1'b0; laser_control_i = 1'b1; laser_out_switch_i = 1'b0;
        amax = 12'd1638; amin = 12'd0; uplim = 12'd4095; lowlim = 12'd0;
        pwm = 32'd10; cyc = 32'd5; mode_sel = 1'b0; trig = 1'b0;
        job = 1'b0; init_sw = 1'b0; init_trig = 1'b0; flag = 1'b0; init_vol = 12'd2457;
        cls[0] = 12'd0;    cls[1] = 12'd819;  cls[2] = 12'd1228; cls[3] = 12'd1500;
        cls[4] = 12'd1600; cls[5] = 12'd1700; cls[6] = 12'd1800; cls[7] = 12'd1900;
        err_c = 1'b0; err_i = 1'b0;

        //            sw  max       min      pwm    cyc    up        low       ec    ei    exp
        vecs[0]  = '{1'b0, 12'd1638, 12'd0,   32'd10, 32'd5, 12'd4095, 12'd0,    1'b0, 1'b0, 12'd0};    // idle
        vecs[1]  = '{1'b1, 12'd1638, 12'd0,   32'd10, 32'd5, 12'd4095, 12'd0,    1'b0, 1'b0, 12'd1638}; // pwm>=cycle
        vecs[2]  = '{1'b1, 12'd1638, 12'd300, 32'd0,  32'd5, 12'd4095, 12'd0,    1'b0, 1'b0, 12'd300};  // pwm=0
        vecs[3]  = '{1'b1, 12'd1638, 12'd300, 32'd5,  32'd0, 12'd4095, 12'd0,    1'b0, 1'b0, 12'd300};  // cycle=0
        vecs[4]  = '{1'b1, 12'd1638, 12'd300, 32'd10, 32'd5, 12'd1000, 12'd0,    1'b0, 1'b0, 12'd1000}; // uplimit
        vecs[5]  = '{1'b1, 12'd1638, 12'd300, 32'd10, 32'd5, 12'd4095, 12'd2000, 1'b0, 1'b0, 12'd2000}; // lowlimit
        vecs[6]  = '{1'b1, 12'd1638, 12'd300, 32'd10, 32'd5, 12'd1000, 12'd3000, 1'b0, 1'b0, 12'd1000}; // crossed
        vecs[7]  = '{1'b1, 12'd1638, 12'd300, 32'd10, 32'd5, 12'd4095, 12'd0,    1'b1, 1'b0, 12'd0};    // err cont
        vecs[8]  = '{1'b1, 12'd1638, 12'd300, 32'd10, 32'd5, 12'd4095, 12'd0,    1'b0, 1'b1, 12'd0};    // err integ
        vecs[9]  = '{1'b1, 12'd4095, 12'd300, 32'd10, 32'd5, 12'd4095, 12'd0,    1'b0, 1'b0, 12'd4095}; // resume
        vecs[10] = '{1'b1, 12'd1638, 12'd300, 32'd0,  32'd5, 12'd200,  12'd0,    1'b0, 1'b0, 12'd200};  // min clamped

        // ---------------- reset ----------------
        #10;
        check("rst_voltage", {20'd0, volt}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_laser_control", {31'd0, LASER_CONTROL}, 32'd0);
        #10 rst_i = 1'b1;
        tick();
        check("first_strobe", {31'd0, en}, 32'd1);
        check("post_rst_voltage", {20'd0, volt}, 32'd0);
        check("laser_control_follow", {31'd0, LASER_CONTROL}, 32'd1);
        $display("reset released: voltage %0d en %0d ctrl %0d", volt, en, LASER_CONTROL);
        laser_control_i = 1'b0;
        tick();
        check("strobe_once", {31'd0, en}, 32'd0);
        check("laser_control_low", {31'd0, LASER_CONTROL}, 32'd0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 11; i++) begin
            laser_out_switch_i = vecs[i].sw;
            amax = vecs[i].vmax; amin = vecs[i].vmin;
            pwm = vecs[i].vpwm;  cyc = vecs[i].vcyc;
            uplim = vecs[i].up;  lowlim = vecs[i].low;
            err_c = vecs[i].ec;  err_i = vecs[i].ei;
            tick();
            check($sformatf("vec%0d_voltage", i), {20'd0, volt}, {20'd0, vecs[i].exp_v});
            check($sformatf("vec%0d_out_switch", i), {31'd0, LASER_OUT_SWITCH}, {31'd0, vecs[i].sw});
            $display("vec %0d: voltage %0d expected %0d", i, volt, vecs[i].exp_v);
        end

        // ---------------- continuous PWM ----------------
        laser_out_switch_i = 1'b0; err_c = 1'b0; err_i = 1'b0;
        tick();
        amax = 12'd1638; amin = 12'd0; pwm = 32'd100; cyc = 32'd200;
        uplim = 12'd4095; lowlim = 12'd0; mode_sel = 1'b0;
        laser_out_switch_i = 1'b1;
        strobes = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            check($sformatf("pwm_k%0d", k), {20'd0, volt}, ((k % 200) < 100) ? 32'd1638 : 32'd0);
            if (en) strobes++;
        end
        check("pwm_strobe_count", strobes, 32'd4);
        $display("pwm mode0: 400 cycles, %0d strobes", strobes);

        // ---------------- single pulse ----------------
        mode_sel = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pulse_idle", {20'd0, volt}, 32'd0);
        end
        for (int k = 0; k < 150; k++) begin
            trig = (k == 0 || k == 50);
            tick();
            check($sformatf("pulse_k%0d", k), {20'd0, volt}, (k < 100) ? 32'd1638 : 32'd0);
        end
        trig = 1'b0;
        $display("pulse mode1: voltage after pulse %0d", volt);

        // ---------------- acceleration job ----------------
        init_sw = 1'b1; init_vol = 12'd2457; job = 1'b1;
        step_acc("job_init", 12'd2457);
        check("job_init_strobe", {31'd0, en}, 32'd1);
        step_acc("job_init_hold", 12'd2457);
        check("job_hold_no_strobe", {31'd0, en}, 32'd0);
        flag = 1'b1; step_acc("flag_rise_class1", 12'd819);
        flag = 1'b0; step_acc("flag_fall_class0", 12'd0);
        flag = 1'b1; step_acc("flag_rise_class2", 12'd1228);
        err_c = 1'b1; step_acc("job_err", 12'd0);
        step_acc("job_err_hold", 12'd0);
        err_c = 1'b0; step_acc("job_err_clear", 12'd1228);
        for (int i = 3; i < 8; i++) begin
            flag = 1'b0; step_acc("adv_fall", 12'd0);
            flag = 1'b1; step_acc($sformatf("adv_class%0d", i), cls[i]);
        end
        flag = 1'b0; step_acc("wrap_fall", 12'd0);
        flag = 1'b1; step_acc("wrap_class1", 12'd819);
        init_trig = 1'b1; step_acc("reinit", 12'd2457);
        init_trig = 1'b0; step_acc("reinit_hold", 12'd2457);
        flag = 1'b0; step_acc("reinit_flag_fall", 12'd2457);
        flag = 1'b1; step_acc("reinit_class1", 12'd819);
        flag = 1'b0; step_acc("reinit_fall", 12'd0);
        flag = 1'b1; step_acc("reinit_class2", 12'd1228);
        job = 1'b0; laser_out_switch_i = 1'b0; step_acc("job_exit_idle", 12'd0);
        cls[0] = 12'd100; init_sw = 1'b0; flag = 1'b0; job = 1'b1;
        step_acc("noinit_class0", 12'd100);
        flag = 1'b1; step_acc("exit_reset_class1", 12'd819);
        uplim = 12'd500; step_acc("job_clamp", 12'd500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
